// File: rtl/ahb2_mem_ws_if.sv
// AHB2 slave-side bus bundle for the wait-state SRAM model.
interface ahb2_mem_ws_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyi;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyo;
  logic [1:0]            hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyi,
    input  hrdata, hreadyo, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyi,
    output hrdata, hreadyo, hresp
  );
endinterface

// File: rtl/ahb2_mem_ws.sv
// AHB2 SRAM slave with byte-lane writes, programmable read/write wait
// states, ERROR responses for illegal accesses and read-after-write forwarding.
module ahb2_mem_ws #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int RD_WAIT    = 0,
  parameter int WR_WAIT    = 0
) (
  input logic           clk,
  input logic           rst_n,
  ahb2_mem_ws_if.slave  ahb_if
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int IW    = ADDR_WIDTH - LB;
  localparam int WORDS = 1 << IW;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {IDLE, RD_WAIT_S, WR_WAIT_S, ERR1, ERR2} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [IW-1:0]         addr_q, addr_d;
  logic [NB-1:0]         strb_q, strb_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic          accept, illegal, take, commit;
  logic [IW-1:0] new_idx;
  logic          unused_sig;

  // Little-endian byte strobes for a transfer of 2^size bytes at lane offset off.
  function automatic logic [NB-1:0] strb_f(input logic [2:0] size, input logic [LB-1:0] off);
    logic [NB-1:0] s;
    int lo, hi;
    lo = int'(off);
    hi = lo + (1 << size);
    for (int i = 0; i < NB; i++) s[i] = (i >= lo) && (i < hi);
    return s;
  endfunction

  // Replace only the strobed byte lanes of old with the new write data.
  function automatic logic [DATA_WIDTH-1:0] merge_f(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] wd,
                                                    input logic [NB-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction

  assign unused_sig = ahb_if.htrans[0];
  assign accept  = ahb_if.hsel & ahb_if.htrans[1] & ahb_if.hreadyi;
  assign new_idx = ahb_if.haddr[ADDR_WIDTH-1:LB];
  assign illegal = (|ahb_if.haddr[31:ADDR_WIDTH]) ||
                   (|(ahb_if.haddr & ((32'd1 << ahb_if.hsize) - 32'd1))) ||
                   (ahb_if.hsize > 3'(LB));
  // The write lands on the edge that ends its final data-phase cycle.
  assign commit  = (state_q == WR_WAIT_S) && (cnt_q == 3'd0);

  // Next-state, wait counter, address-phase capture and read data selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    strb_d   = strb_q;
    hrdata_d = '0;
    take     = 1'b0;
    case (state_q)
      IDLE: take = 1'b1;
      RD_WAIT_S, WR_WAIT_S: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               take  = 1'b1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
    // Array read for a waited read happens one cycle before its final data cycle.
    if ((state_q == RD_WAIT_S) && (cnt_q == 3'd1)) hrdata_d = mem_q[addr_q];
    if (take) begin
      state_d = IDLE;
      if (accept) begin
        if (illegal) begin
          state_d = ERR1;
        end else begin
          addr_d = new_idx;
          strb_d = strb_f(ahb_if.hsize, ahb_if.haddr[LB-1:0]);
          if (ahb_if.hwrite) begin
            state_d = WR_WAIT_S;
            cnt_d   = 3'(WR_WAIT);
          end else begin
            state_d = RD_WAIT_S;
            cnt_d   = 3'(RD_WAIT);
            // Zero-wait read: fetch now, forwarding a write committing on this edge.
            if (RD_WAIT == 0) begin
              if (commit && (addr_q == new_idx))
                hrdata_d = merge_f(mem_q[addr_q], ahb_if.hwdata, strb_q);
              else
                hrdata_d = mem_q[new_idx];
            end
          end
        end
      end
    end
  end

  // Control and read-data registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Address and strobe capture for the transfer in its data phase.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    strb_q <= strb_d;
  end

  // Byte-lane write into the array at the end of the final write cycle.
  always_ff @(posedge clk) begin
    if (commit) mem_q[addr_q] <= merge_f(mem_q[addr_q], ahb_if.hwdata, strb_q);
  end

  // Response outputs decoded from the current state and wait counter.
  always_comb begin
    ahb_if.hreadyo = 1'b1;
    ahb_if.hresp   = HRESP_OKAY;
    ahb_if.hrdata  = hrdata_q;
    case (state_q)
      RD_WAIT_S, WR_WAIT_S: ahb_if.hreadyo = (cnt_q == 3'd0);
      ERR1: begin
        ahb_if.hreadyo = 1'b0;
        ahb_if.hresp   = HRESP_ERROR;
      end
      ERR2: ahb_if.hresp = HRESP_ERROR;
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  task init_mem();
    for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
  endtask

  task init_mem_with_addr();
    for (int i = 0; i < WORDS; i++) mem_q[i] <= DATA_WIDTH'(i);
  endtask

  task read_word(input logic [31:0] addr, output logic [DATA_WIDTH-1:0] rdata);
    rdata = mem_q[addr[ADDR_WIDTH-1:LB]];
  endtask

  task write_word(input logic [31:0] addr, input logic [DATA_WIDTH-1:0] wdata);
    mem_q[addr[ADDR_WIDTH-1:LB]] <= wdata;
  endtask
`endif

endmodule
